// File: rtl/edge_detector_pkg.sv
// Shared types and defaults for the Sobel edge-detector controller.
// Build option: EDGE_DETECTOR_CTRL_CYCLE_COUNT_EN enables the job-cycle counter.
package edge_detector_pkg;

  localparam int KX_SIZE_DEFAULT         = 3;
  localparam int KY_SIZE_DEFAULT         = 3;
  localparam int CYCLE_CNT_WIDTH_DEFAULT = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INIT     = 3'd1,
    LOAD     = 3'd2,
    CALC     = 3'd3,
    OUT_INIT = 3'd4,
    OUT      = 3'd5,
    DONE     = 3'd6
  } ctrlState_t;

  // Every controller-driven datapath strobe plus the handshake/status outputs.
  typedef struct packed {
    logic cntrInputClear;
    logic cntrKernelClear;
    logic cntrMemGclear;
    logic memGclear;
    logic memImgWr;
    logic cntrInputInc;
    logic saveImgOrCalculate;
    logic cntrKernelInc;
    logic memGwr;
    logic cntrMemGinc;
    logic pixelReady;
    logic outValid;
    logic done;
  } ctrlStrobes_t;

  localparam ctrlStrobes_t STROBES_NONE = '0;

  function automatic logic isBusy(input ctrlState_t state);
    return state != IDLE;
  endfunction

endpackage

// File: rtl/edge_detector_ctrl_cycle_counter.sv
// Saturating job-cycle counter: cleared when a job is accepted, counts busy cycles.
// Instantiated by edge_detector_controller only under EDGE_DETECTOR_CTRL_CYCLE_COUNT_EN.
module edge_detector_ctrl_cycle_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count <= '0;
    end else if (clear_i) begin
      count <= '0;
    end else if (enable_i && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  assign count_o = count;

endmodule

// File: rtl/edge_detector_controller.sv
// Sequencing FSM for the Sobel edge-detector datapath: load image, run 9-tap MAC, stream out.
// Build option: EDGE_DETECTOR_CTRL_CYCLE_COUNT_EN adds the job-cycle counter on cycleCount_o.
module edge_detector_controller
  import edge_detector_pkg::*;
#(
  parameter int KX_SIZE         = KX_SIZE_DEFAULT,
  parameter int KY_SIZE         = KY_SIZE_DEFAULT,
  parameter int CYCLE_CNT_WIDTH = CYCLE_CNT_WIDTH_DEFAULT
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic                       pixelValid_i,
  input  logic                       outReady_i,
  input  logic                       inputRecieved_i,
  input  logic                       kernelResReady_i,
  input  logic                       imageProcessed_i,
  output logic                       cntrInputClear_o,
  output logic                       cntrKernelClear_o,
  output logic                       cntrMemGclear_o,
  output logic                       memGclear_o,
  output logic                       memImgWr_o,
  output logic                       cntrInputInc_o,
  output logic                       saveImgOrCalculate_o,
  output logic                       cntrKernelInc_o,
  output logic                       memGwr_o,
  output logic                       cntrMemGinc_o,
  output logic                       pixelReady_o,
  output logic                       outValid_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [CYCLE_CNT_WIDTH-1:0] cycleCount_o
);

  // Tap sequencing is driven by the datapath's kernel counter; the kernel size only needs to be sane.
  if (KX_SIZE * KY_SIZE < 2) begin : gBadKernel
    $error("edge_detector_controller: kernel must have at least two taps");
  end

  ctrlState_t   state;
  ctrlState_t   nextState;
  ctrlStrobes_t strobes;
  logic         startAccepted;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    nextState = state;
    strobes   = STROBES_NONE;

    unique case (state)
      IDLE: begin
        if (start_i) nextState = INIT;
      end

      INIT: begin
        strobes.cntrInputClear  = 1'b1;
        strobes.cntrKernelClear = 1'b1;
        strobes.cntrMemGclear   = 1'b1;
        strobes.memGclear       = 1'b1;
        nextState               = LOAD;
      end

      LOAD: begin
        strobes.pixelReady = 1'b1;
        if (pixelValid_i) begin
          strobes.memImgWr     = 1'b1;
          strobes.cntrInputInc = 1'b1;
          if (inputRecieved_i) nextState = CALC;
        end
      end

      // One kernel tap per cycle; the last tap rewinds the kernel counter and advances the pixel.
      CALC: begin
        strobes.saveImgOrCalculate = 1'b1;
        strobes.memGwr             = 1'b1;
        if (!kernelResReady_i) begin
          strobes.cntrKernelInc = 1'b1;
        end else begin
          strobes.cntrKernelClear = 1'b1;
          if (!imageProcessed_i) begin
            strobes.cntrMemGinc = 1'b1;
          end else begin
            nextState = OUT_INIT;
          end
        end
      end

      OUT_INIT: begin
        strobes.cntrMemGclear = 1'b1;
        nextState             = OUT;
      end

      OUT: begin
        strobes.outValid           = 1'b1;
        strobes.saveImgOrCalculate = 1'b1;
        if (outReady_i) begin
          strobes.cntrMemGinc = 1'b1;
          if (imageProcessed_i) nextState = DONE;
        end
      end

      DONE: begin
        strobes.done = 1'b1;
        nextState    = IDLE;
      end

      default: nextState = IDLE;
    endcase

    // Abort wins over everything, including a simultaneous start in IDLE.
    if (abort_i) begin
      nextState = IDLE;
      strobes   = STROBES_NONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  assign startAccepted = (state == IDLE) && start_i && !abort_i;

  assign cntrInputClear_o     = strobes.cntrInputClear;
  assign cntrKernelClear_o    = strobes.cntrKernelClear;
  assign cntrMemGclear_o      = strobes.cntrMemGclear;
  assign memGclear_o          = strobes.memGclear;
  assign memImgWr_o           = strobes.memImgWr;
  assign cntrInputInc_o       = strobes.cntrInputInc;
  assign saveImgOrCalculate_o = strobes.saveImgOrCalculate;
  assign cntrKernelInc_o      = strobes.cntrKernelInc;
  assign memGwr_o             = strobes.memGwr;
  assign cntrMemGinc_o        = strobes.cntrMemGinc;
  assign pixelReady_o         = strobes.pixelReady;
  assign outValid_o           = strobes.outValid;
  assign done_o               = strobes.done;
  assign busy_o               = isBusy(state);

`ifdef EDGE_DETECTOR_CTRL_CYCLE_COUNT_EN
  edge_detector_ctrl_cycle_counter #(
    .WIDTH (CYCLE_CNT_WIDTH)
  ) uCycleCounter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (startAccepted),
    .enable_i (busy_o),
    .count_o  (cycleCount_o)
  );
`else
  logic unusedStart;
  assign unusedStart  = startAccepted;
  assign cycleCount_o = '0;
`endif

endmodule

// File: tb/tb_edge_detector_controller.sv
// Directed self-checking bench for edge_detector_controller with a 4x4 image / 3x3 kernel datapath model.
module tb_edge_detector_controller;

  localparam int CW         = 32;
  localparam int IMG_PIXELS = 16;
  localparam int TAPS       = 9;
  localparam int OUT_PIXELS = 4;
  localparam int CALC_CYCLES = TAPS * OUT_PIXELS;
  // INIT + 16 LOAD + 36 CALC + OUT_INIT + 4 OUT + DONE
  localparam int BASE_CYCLES = 59;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic start_i = 1'b0;
  logic abort_i = 1'b0;
  logic pixelValid_i = 1'b0;
  logic outReady_i = 1'b0;
  logic inputRecieved_i, kernelResReady_i, imageProcessed_i;
  logic cntrInputClear_o, cntrKernelClear_o, cntrMemGclear_o, memGclear_o;
  logic memImgWr_o, cntrInputInc_o, saveImgOrCalculate_o, cntrKernelInc_o;
  logic memGwr_o, cntrMemGinc_o, pixelReady_o, outValid_o, busy_o, done_o;
  logic [CW-1:0] cycleCount_o;

  int checks = 0;
  int errors = 0;
  int inCnt = 0;
  int kCnt = 0;
  int gCnt = 0;

  edge_detector_controller #(
    .KX_SIZE(3), .KY_SIZE(3), .CYCLE_CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .pixelValid_i(pixelValid_i), .outReady_i(outReady_i),
    .inputRecieved_i(inputRecieved_i), .kernelResReady_i(kernelResReady_i),
    .imageProcessed_i(imageProcessed_i),
    .cntrInputClear_o(cntrInputClear_o), .cntrKernelClear_o(cntrKernelClear_o),
    .cntrMemGclear_o(cntrMemGclear_o), .memGclear_o(memGclear_o),
    .memImgWr_o(memImgWr_o), .cntrInputInc_o(cntrInputInc_o),
    .saveImgOrCalculate_o(saveImgOrCalculate_o), .cntrKernelInc_o(cntrKernelInc_o),
    .memGwr_o(memGwr_o), .cntrMemGinc_o(cntrMemGinc_o),
    .pixelReady_o(pixelReady_o), .outValid_o(outValid_o),
    .busy_o(busy_o), .done_o(done_o), .cycleCount_o(cycleCount_o)
  );

  always #5 clk_i = ~clk_i;

  // Datapath counter model: each flag is "counter at last index".
  always @(posedge clk_i) begin
    if (cntrInputClear_o) inCnt <= 0;
    else if (cntrInputInc_o) inCnt <= inCnt + 1;
    if (cntrKernelClear_o) kCnt <= 0;
    else if (cntrKernelInc_o) kCnt <= kCnt + 1;
    if (cntrMemGclear_o) gCnt <= 0;
    else if (cntrMemGinc_o) gCnt <= gCnt + 1;
  end

  assign inputRecieved_i  = (inCnt == IMG_PIXELS - 1);
  assign kernelResReady_i = (kCnt == TAPS - 1);
  assign imageProcessed_i = (gCnt == OUT_PIXELS - 1);

  wire [12:0] allStrobes = {cntrInputClear_o, cntrKernelClear_o, cntrMemGclear_o, memGclear_o,
                            memImgWr_o, cntrInputInc_o, saveImgOrCalculate_o, cntrKernelInc_o,
                            memGwr_o, cntrMemGinc_o, pixelReady_o, outValid_o, done_o};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Runs one full job from IDLE; on return the controller is back in IDLE, just after a rising edge.
  task automatic run_job(input string tag, input bit toggleValid, input bit stallOut);
    int wr = 0, invalidWr = 0, loadCyc = 0, calcCyc = 0, calcErr = 0;
    int memGincOut = 0, hs = 0, doneCnt = 0, stallLeft = 5, stallSeen = 0, stallErr = 0;
    int cyc = 0, lastCalcIdx = -10, outInitIdx = -20;
    bit fin = 1'b0, stallNow;
    logic [CW-1:0] expCount;

    tick();
    issue_start();
    check({tag, " init_clears"},
          {63'd0, cntrInputClear_o & cntrKernelClear_o & cntrMemGclear_o & memGclear_o}, 64'd1);
    check({tag, " init_busy"}, {63'd0, busy_o}, 64'd1);

    while (!fin && cyc < 2000) begin
      pixelValid_i = pixelReady_o ? (toggleValid ? ((loadCyc % 2) == 0) : 1'b1) : 1'b0;
      stallNow = outValid_o && stallOut && (hs == 1) && (stallLeft > 0);
      if (stallNow) stallLeft--;
      outReady_i = outValid_o && !stallNow;
      @(negedge clk_i);
      if (pixelReady_o) begin
        loadCyc++;
        if (memImgWr_o) wr++;
        if (!pixelValid_i && (memImgWr_o || cntrInputInc_o)) invalidWr++;
      end
      if (memGwr_o) begin
        bit lastTap;
        lastTap = ((calcCyc % TAPS) == TAPS - 1);
        if (cntrKernelInc_o !== !lastTap || cntrKernelClear_o !== lastTap ||
            cntrMemGinc_o !== (lastTap && calcCyc != CALC_CYCLES - 1) ||
            saveImgOrCalculate_o !== 1'b1)
          calcErr++;
        calcCyc++;
        lastCalcIdx = cyc;
      end
      if (cntrMemGclear_o && !cntrInputClear_o) outInitIdx = cyc;
      if (outValid_o) begin
        if (outReady_i) hs++;
        if (cntrMemGinc_o) memGincOut++;
      end
      if (stallNow) begin
        stallSeen++;
        if (outValid_o !== 1'b1 || cntrMemGinc_o !== 1'b0) stallErr++;
      end
      if (done_o) begin
        doneCnt++;
        fin = 1'b1;
      end else begin
        tick();
        cyc++;
      end
    end
    check({tag, " job_completed"}, {63'd0, fin}, 64'd1);
    pixelValid_i = 1'b0;
    outReady_i   = 1'b0;
    tick();
    check({tag, " idle_after_done"}, {63'd0, busy_o}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      if (done_o) doneCnt++;
      tick();
    end

    check({tag, " img_writes"}, wr, IMG_PIXELS);
    check({tag, " writes_on_invalid"}, invalidWr, 0);
    check({tag, " load_cycles"}, loadCyc, toggleValid ? 31 : IMG_PIXELS);
    check({tag, " calc_cycles"}, calcCyc, CALC_CYCLES);
    check({tag, " calc_tap_pattern_errs"}, calcErr, 0);
    check({tag, " out_init_after_calc"}, {63'd0, outInitIdx == lastCalcIdx + 1}, 64'd1);
    check({tag, " out_handshakes"}, hs, OUT_PIXELS);
    check({tag, " out_memg_incs"}, memGincOut, OUT_PIXELS);
    check({tag, " done_pulses"}, doneCnt, 1);
    if (stallOut) begin
      check({tag, " stall_cycles"}, stallSeen, 5);
      check({tag, " stall_hold_errs"}, stallErr, 0);
    end
`ifdef EDGE_DETECTOR_CTRL_CYCLE_COUNT_EN
    expCount = CW'(BASE_CYCLES + (toggleValid ? 15 : 0) + (stallOut ? 5 : 0));
`else
    expCount = '0;
`endif
    check({tag, " cycle_count"}, {32'd0, cycleCount_o}, {32'd0, expCount});
  endtask

  initial begin
    int guard;
    int doneSeen;

    // Reset state
    #1;
    check("reset_busy", {63'd0, busy_o}, 64'd0);
    check("reset_strobes", {51'd0, allStrobes}, 64'd0);
    check("reset_cycle_count", {32'd0, cycleCount_o}, 64'd0);
    #20;
    rst_i = 1'b1;
    tick();

    // Baseline job, then input-toggle job, then output-stall job
    run_job("basic", 1'b0, 1'b0);
    run_job("toggle_valid", 1'b1, 1'b0);
    run_job("out_stall", 1'b0, 1'b1);

    // start and abort together in IDLE: abort wins
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    check("start_abort_idle_busy", {63'd0, busy_o}, 64'd0);
    check("start_abort_idle_strobes", {51'd0, allStrobes}, 64'd0);

    // Asynchronous reset in the middle of CALC
    issue_start();
    guard = 0;
    while (guard < 200) begin
      pixelValid_i = pixelReady_o;
      @(negedge clk_i);
      if (memGwr_o) guard += 50;
      tick();
      guard++;
      if (guard >= 100 && guard < 200 && memGwr_o) break;
    end
    check("reset_test_reached_calc", {63'd0, memGwr_o}, 64'd1);
    pixelValid_i = 1'b0;
    rst_i = 1'b0;
    #1;
    check("midcalc_reset_busy", {63'd0, busy_o}, 64'd0);
    check("midcalc_reset_strobes", {51'd0, allStrobes}, 64'd0);
    check("midcalc_reset_cycle_count", {32'd0, cycleCount_o}, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();
    tick();
    check("post_reset_idle", {63'd0, busy_o}, 64'd0);

    // Abort in OUT, then restart and complete a full job
    issue_start();
    guard = 0;
    while (!outValid_o && guard < 200) begin
      pixelValid_i = pixelReady_o;
      tick();
      guard++;
    end
    check("abort_reached_out", {63'd0, outValid_o}, 64'd1);
    pixelValid_i = 1'b0;
    abort_i = 1'b1;
    outReady_i = 1'b1;
    @(negedge clk_i);
    check("abort_strobes_forced", {51'd0, allStrobes}, 64'd0);
    tick();
    abort_i = 1'b0;
    outReady_i = 1'b0;
    check("abort_idle_next", {63'd0, busy_o}, 64'd0);
    doneSeen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if (done_o || busy_o) doneSeen++;
      tick();
    end
    check("abort_no_done", doneSeen, 0);
    run_job("after_abort", 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
